trig_arbiter: RTL and testbench

TRIG_ARBITER -- requirements
Module: trig_arbiter

---
 rtl/trig_arbiter_if.sv | 35 +++
 rtl/trig_arbiter.sv | 122 ++++++++++++
 tb/tb_trig_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_arbiter_if.sv
// Bundles the request, shared-datapath and response signals of trig_arbiter.
//   slave  : view taken by trig_arbiter itself
//   master : view taken by whoever drives requests, models the datapath and sinks responses
// Request side : req_valid[4], req_x[4x32], req_sel[4] in; req_ready[4] (one-hot grant) out
// Datapath side: dp_x[32], dp_sel out; dp_sin_y[10]/dp_sin_sig, dp_cos_y[8]/dp_cos_sig in
// Response side: rsp_valid, rsp_id[2], rsp_y[10], rsp_sig out; rsp_ready in
interface trig_arbiter_if;
  logic [3:0]   req_valid;
  logic [127:0] req_x;
  logic [3:0]   req_sel;
  logic [3:0]   req_ready;

  logic [31:0]  dp_x;
  logic         dp_sel;
  logic [9:0]   dp_sin_y;
  logic         dp_sin_sig;
  logic [7:0]   dp_cos_y;
  logic         dp_cos_sig;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [9:0]   rsp_y;
  logic         rsp_sig;

  modport slave (
    input  req_valid, req_x, req_sel, dp_sin_y, dp_sin_sig, dp_cos_y, dp_cos_sig, rsp_ready,
    output req_ready, dp_x, dp_sel, rsp_valid, rsp_id, rsp_y, rsp_sig
  );

  modport master (
    output req_valid, req_x, req_sel, dp_sin_y, dp_sin_sig, dp_cos_y, dp_cos_sig, rsp_ready,
    input  req_ready, dp_x, dp_sel, rsp_valid, rsp_id, rsp_y, rsp_sig
  );
endinterface

// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one sine/cosine datapath between four requesters.
// One operation is in flight at a time: grant in IDLE, wait LAT cycles for the
// datapath to settle, capture the result and hold it in RESP until accepted.
// Ports:
//   iCLK    : clock, rising edge
//   iRST_N  : asynchronous active-low reset
//   bus     : trig_arbiter_if.slave (request, datapath and response signals)
//   busy    : high whenever the FSM is not idle
//   op_cnt  : number of completed responses, wraps at 16 bits
module trig_arbiter #(
  parameter int unsigned LAT = 3
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  trig_arbiter_if.slave        bus,
  output logic                 busy,
  output logic [15:0]          op_cnt
);

  // Out-of-range settle counts saturate into 1..15.
  localparam logic [3:0] LatEff = (LAT < 1) ? 4'd1 : (LAT > 15) ? 4'd15 : 4'(LAT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [1:0]  last_grant_q;
  logic [3:0]  wait_cnt_q;
  logic [31:0] dp_x_q;
  logic        dp_sel_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_id_q;
  logic [9:0]  rsp_y_q;
  logic        rsp_sig_q;
  logic [15:0] op_cnt_q;

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;

  // Search from the requester after the last one served, wrapping modulo 4.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = 4'b0000;
    if (state_q == StIdle && gnt_found) begin
      bus.req_ready = 4'b0001 << gnt_idx;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= StIdle;
      last_grant_q <= 2'd3;
      wait_cnt_q   <= 4'd0;
      dp_x_q       <= 32'd0;
      dp_sel_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 2'd0;
      rsp_y_q      <= 10'd0;
      rsp_sig_q    <= 1'b0;
      op_cnt_q     <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          // A grant is always accepted: req_ready only goes to a valid requester.
          if (gnt_found) begin
            dp_x_q     <= bus.req_x[{gnt_idx, 5'b00000} +: 32];
            dp_sel_q   <= bus.req_sel[gnt_idx];
            rsp_id_q   <= gnt_idx;
            wait_cnt_q <= LatEff;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'd1) begin
            if (dp_sel_q) begin
              rsp_y_q   <= {2'b00, bus.dp_cos_y};
              rsp_sig_q <= bus.dp_cos_sig;
            end else begin
              rsp_y_q   <= bus.dp_sin_y;
              rsp_sig_q <= bus.dp_sin_sig;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            last_grant_q <= rsp_id_q;
            op_cnt_q     <= op_cnt_q + 16'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dp_x      = dp_x_q;
  assign bus.dp_sel    = dp_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_sig   = rsp_sig_q;
  assign busy          = (state_q != StIdle);
  assign op_cnt        = op_cnt_q;

endmodule

// File: tb/tb_trig_arbiter.sv
module tb_trig_arbiter;
  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] op_cnt;

  trig_arbiter_if bus ();

  trig_arbiter #(.LAT(LAT)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus),
    .busy   (busy),
    .op_cnt (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one job in flight, aged in clock edges.
  bit          m_busy;
  int          m_age;
  logic [1:0]  m_id;
  logic [1:0]  m_last;
  logic        m_sel;
  logic [9:0]  m_y;
  logic        m_sig;
  logic [15:0] m_cnt;
  logic [31:0] m_dpx;
  logic        m_dpsel;
  logic [3:0]  seen_ready;

  task automatic model_reset();
    m_busy  = 0;
    m_age   = 0;
    m_id    = 2'd0;
    m_last  = 2'd3;
    m_sel   = 1'b0;
    m_y     = 10'd0;
    m_sig   = 1'b0;
    m_cnt   = 16'd0;
    m_dpx   = 32'd0;
    m_dpsel = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model across
  // the next rising edge, return 1 time unit after it.
  task automatic step();
    logic [3:0] exp_ready;
    int         pick;
    bit         exp_valid;
    @(negedge clk);
    exp_ready = 4'b0000;
    pick = -1;
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (int'(m_last) + k) % 4;
        if (pick < 0 && bus.req_valid[idx]) pick = idx;
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
    end
    exp_valid  = m_busy && (m_age >= LAT);
    seen_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
    check("op_cnt", 32'(op_cnt), 32'(m_cnt));
    check("dp_x", bus.dp_x, m_dpx);
    check("dp_sel", 32'(bus.dp_sel), 32'(m_dpsel));
    if (exp_valid) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_y", 32'(bus.rsp_y), 32'(m_y));
      check("rsp_sig", 32'(bus.rsp_sig), 32'(m_sig));
    end
    // Result is taken from the datapath during the last settle cycle.
    if (m_busy && m_age == LAT - 1) begin
      m_y   = m_sel ? {2'b00, bus.dp_cos_y} : bus.dp_sin_y;
      m_sig = m_sel ? bus.dp_cos_sig : bus.dp_sin_sig;
    end
    if (!m_busy && pick >= 0) begin
      m_busy  = 1;
      m_age   = 0;
      m_id    = 2'(pick);
      m_sel   = bus.req_sel[pick];
      m_dpx   = bus.req_x[pick*32 +: 32];
      m_dpsel = bus.req_sel[pick];
    end else if (m_busy) begin
      if (m_age >= LAT && bus.rsp_ready) begin
        m_busy = 0;
        m_last = m_id;
        m_cnt  = m_cnt + 16'd1;
      end else if (m_age < LAT) begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    bus.req_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
    bus.req_x      = {$urandom, $urandom, $urandom, $urandom};
    bus.req_sel    = 4'($urandom_range(0, 15));
    bus.dp_sin_y   = 10'($urandom_range(0, 1023));
    bus.dp_sin_sig = 1'($urandom_range(0, 1));
    bus.dp_cos_y   = 8'($urandom_range(0, 255));
    bus.dp_cos_sig = 1'($urandom_range(0, 1));
    bus.rsp_ready  = ($urandom_range(0, 9) < 6);
  endtask

  task automatic drain();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < LAT + 4; i++) step();
  endtask

  int grant_idx[$];
  int grant_cyc[$];

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 4'b0000;
    bus.req_x      = 128'd0;
    bus.req_sel    = 4'b0000;
    bus.dp_sin_y   = 10'd0;
    bus.dp_sin_sig = 1'b0;
    bus.dp_cos_y   = 8'd0;
    bus.dp_cos_sig = 1'b0;
    bus.rsp_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_dp_x", bus.dp_x, 32'd0);
    check("rst_rsp_y", 32'({bus.rsp_id, bus.rsp_y, bus.rsp_sig, bus.dp_sel}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin from reset: all requesters always valid.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    bus.req_x     = {32'd400, 32'd300, 32'd200, 32'd100};
    bus.req_sel   = 4'b1010;
    for (int c = 0; c < 22; c++) begin
      step();
      if (seen_ready != 4'b0000) begin
        grant_idx.push_back($clog2(int'(seen_ready)));
        grant_cyc.push_back(c);
      end
    end
    check("rr_grants", 32'(grant_idx.size()), 32'd5);
    for (int k = 0; k < grant_idx.size() && k < 5; k++) begin
      check("rr_order", 32'(grant_idx[k]), 32'(k % 4));
      if (k > 0) check("rr_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'(LAT + 2));
    end
    drain();

    // Single sine request with a fixed datapath answer.
    bus.req_valid  = 4'b0001;
    bus.req_x      = {96'd0, 32'd1571};
    bus.req_sel    = 4'b0000;
    bus.dp_sin_y   = 10'd1023;
    bus.dp_sin_sig = 1'b0;
    step();
    check("sine_grant", 32'(seen_ready), 32'b0001);
    bus.req_valid = 4'b0000;
    for (int i = 0; i < LAT + 2; i++) step();
    check("sine_done", 32'(op_cnt - grant_idx.size()), 32'd1);

    // Cosine result is zero-extended.
    bus.req_valid  = 4'b0100;
    bus.req_sel    = 4'b0100;
    bus.dp_cos_y   = 8'hFF;
    bus.dp_cos_sig = 1'b1;
    bus.rsp_ready  = 1'b0;
    step();
    bus.req_valid = 4'b0000;
    for (int i = 0; i < LAT; i++) step();
    check("cos_y", 32'(bus.rsp_y), 32'h0FF);
    check("cos_sig", 32'(bus.rsp_sig), 32'd1);

    // Backpressure: all requesters valid, response held for 10 cycles.
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) step();
    drain();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      drive_random();
      step();
    end
    drain();

    // Reset one cycle after an acceptance.
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0000;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) step();
    bus.req_valid = 4'b1111;
    step();
    check("post_rst_grant", 32'(seen_ready), 32'b0001);
    drain();

    // Counter wrap: preload 0xFFFF, then complete one more operation.
    force dut.op_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_cnt_q;
    @(posedge clk);
    #1;
    m_cnt = 16'hFFFF;
    bus.req_valid = 4'b1000;
    step();
    drain();
    check("wrap", 32'(op_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
